unified_mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory between the multicycle core's memory port (CPU) and a DMA/debug port.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/sat_counter.sv | 28 ++
 rtl/unified_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM state encoding and port-owner identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that saturates at MAX; term flags the saturated value.
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         term
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign term = (count == MAX_V);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !term) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single unified memory between the core (CPU) and the DMA/debug port,
// with a DMA starvation guard and a memory-latency watchdog.
//
//  state | meaning
//  IDLE  | no access in flight; arbitrate any pending request
//  BUSY  | latched access presented to memory until mem_ready or watchdog expiry
//  DONE  | one-cycle done pulse to the owner with registered rdata/err
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_err,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t    state, state_next;
    logic          owner;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    logic          start, contested, win_dma;
    logic          busy, done;
    logic [3:0]    starve_cnt;
    logic          starve_term;
    logic [7:0]    wd_cnt;
    logic          wd_term;

    assign busy      = (state == ST_BUSY);
    assign done      = (state == ST_DONE);
    assign contested = cpu_req && dma_req;
    assign win_dma   = dma_req && (!cpu_req || (starve_cnt == STARVE_MAX));

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    state_next = ST_BUSY;
                    start      = 1'b1;
                end
            end
            ST_BUSY: begin
                if (mem_ready || wd_term) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    sat_counter #(.W(4), .MAX(STARVE_LIMIT)) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start && win_dma),
        .inc   (start && contested && !starve_term),
        .count (starve_cnt),
        .term  (starve_term)
    );

    // Terminal count marks the last BUSY cycle the watchdog allows.
    sat_counter #(.W(8), .MAX(TIMEOUT - 1)) u_wd_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (!busy),
        .inc   (busy),
        .count (wd_cnt),
        .term  (wd_term)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            owner   <= OWNER_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                owner   <= win_dma ? OWNER_DMA : OWNER_CPU;
                we_q    <= win_dma ? dma_we    : cpu_we;
                addr_q  <= win_dma ? dma_addr  : cpu_addr;
                wdata_q <= win_dma ? dma_wdata : cpu_wdata;
            end
            // mem_ready takes precedence over a simultaneous watchdog expiry.
            if (busy && mem_ready) begin
                rdata_q <= we_q ? '0 : mem_rdata;
                err_q   <= 1'b0;
            end else if (busy && wd_term) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign cpu_gnt   = busy && (wd_cnt == 8'd0) && (owner == OWNER_CPU);
    assign dma_gnt   = busy && (wd_cnt == 8'd0) && (owner == OWNER_DMA);
    assign cpu_done  = done && (owner == OWNER_CPU);
    assign dma_done  = done && (owner == OWNER_DMA);
    assign cpu_rdata = cpu_done ? rdata_q : '0;
    assign dma_rdata = dma_done ? rdata_q : '0;
    assign cpu_err   = cpu_done && err_q;
    assign dma_err   = dma_done && err_q;

    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_addr  = busy ? addr_q  : '0;
    assign mem_wdata = busy ? wdata_q : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed, table-driven bench for unified_mem_arbiter plus hand-written starvation and reset sequences.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_done, cpu_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_done, dma_err;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    typedef struct {
        string       name;
        logic        c_req;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        d_req;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        we;
        int          ready_at;   // BUSY cycle in which mem_ready is driven; 0 = never
        logic [31:0] mrd;
        logic        poke;       // change cpu_addr after grant
        logic        exp_dma;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_busy;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(string name,
                                logic c_req, logic [31:0] c_addr, logic [31:0] c_wdata,
                                logic d_req, logic [31:0] d_addr, logic [31:0] d_wdata,
                                logic we, int ready_at, logic [31:0] mrd, logic poke,
                                logic exp_dma, logic [31:0] exp_addr, logic [31:0] exp_wdata,
                                int exp_busy, logic [31:0] exp_rdata, logic exp_err);
        vec_t v;
        v.name = name; v.c_req = c_req; v.c_addr = c_addr; v.c_wdata = c_wdata;
        v.d_req = d_req; v.d_addr = d_addr; v.d_wdata = d_wdata; v.we = we;
        v.ready_at = ready_at; v.mrd = mrd; v.poke = poke; v.exp_dma = exp_dma;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_busy = exp_busy;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_txn(input vec_t v);
        int          busy_cnt;
        bit          done_seen, gnt_ok, hold_ok, other_quiet;
        logic        done_dma, er;
        logic [31:0] rd;
        busy_cnt = 0; done_seen = 0; gnt_ok = 1; hold_ok = 1; other_quiet = 1;
        done_dma = 1'b0; er = 1'b0; rd = '0;
        @(negedge clk);
        cpu_req = v.c_req; cpu_addr = v.c_addr; cpu_wdata = v.c_wdata; cpu_we = v.we;
        dma_req = v.d_req; dma_addr = v.d_addr; dma_wdata = v.d_wdata; dma_we = v.we;
        mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (cpu_gnt !== !v.exp_dma || dma_gnt !== v.exp_dma) gnt_ok = 0;
            end else if (cpu_gnt || dma_gnt) begin
                gnt_ok = 0;
            end
            if (mem_req) begin
                busy_cnt++;
                if (mem_addr !== v.exp_addr || mem_we !== v.we || mem_wdata !== v.exp_wdata)
                    hold_ok = 0;
            end
            if (cpu_done || dma_done) begin
                done_seen = 1;
                done_dma  = dma_done;
                rd        = dma_done ? dma_rdata : cpu_rdata;
                er        = dma_done ? dma_err : cpu_err;
                if (cpu_done && dma_done) other_quiet = 0;
                if (dma_done ? (cpu_rdata !== 0 || cpu_err !== 0) : (dma_rdata !== 0 || dma_err !== 0))
                    other_quiet = 0;
                if (cpu_gnt || dma_gnt || mem_req) gnt_ok = 0;
                cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
            end else begin
                if (v.poke && c == 0) cpu_addr = ~v.c_addr;
                if (mem_req && v.ready_at != 0 && busy_cnt == v.ready_at) begin
                    mem_ready = 1'b1; mem_rdata = v.mrd;
                end else begin
                    mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
                end
            end
        end
        check({v.name, "_done_seen"}, 32'(done_seen), 32'd1);
        check({v.name, "_owner"},     32'(done_dma), 32'(v.exp_dma));
        check({v.name, "_busy"},      32'(busy_cnt), 32'(v.exp_busy));
        check({v.name, "_rdata"},     rd, v.exp_rdata);
        check({v.name, "_err"},       32'(er), 32'(v.exp_err));
        check({v.name, "_gnt"},       32'(gnt_ok), 32'd1);
        check({v.name, "_mem_hold"},  32'(hold_ok), 32'd1);
        check({v.name, "_other"},     32'(other_quiet), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          ng;
        bit          both, seen;
        logic [9:0]  order_got;
        logic [9:0]  order_exp;

        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        mem_ready = 0; mem_rdata = '0;

        @(negedge clk);
        check("rst_mem_req",  32'(mem_req), 32'd0);
        check("rst_gnt",      32'({cpu_gnt, dma_gnt}), 32'd0);
        check("rst_done",     32'({cpu_done, dma_done}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        //              name              c_req c_addr     c_wdata    d_req d_addr     d_wdata    we ready mrd           poke dma exp_addr   exp_wdata  busy rdata         err
        vecs[0] = mk("cpu_load",           1, 32'h100, 32'h0,      0, 32'h0,   32'h0,      0, 2,  32'hDEADBEEF, 0,   0, 32'h100, 32'h0,      2,  32'hDEADBEEF, 0);
        vecs[1] = mk("dma_store_timeout",  0, 32'h0,   32'h0,      1, 32'h200, 32'h55AA,   1, 0,  32'h0BAD0BAD, 0,   1, 32'h200, 32'h55AA,   15, 32'h0,        1);
        vecs[2] = mk("ready_at_limit",     1, 32'h300, 32'h0,      0, 32'h0,   32'h0,      0, 15, 32'h12345678, 0,   0, 32'h300, 32'h0,      15, 32'h12345678, 0);
        vecs[3] = mk("ready_before_limit", 1, 32'h380, 32'h0,      0, 32'h0,   32'h0,      0, 14, 32'h0BADF00D, 0,   0, 32'h380, 32'h0,      14, 32'h0BADF00D, 0);
        vecs[4] = mk("dma_load",           0, 32'h0,   32'h0,      1, 32'h400, 32'h0,      0, 1,  32'hCAFEF00D, 0,   1, 32'h400, 32'h0,      1,  32'hCAFEF00D, 0);
        vecs[5] = mk("cpu_store",          1, 32'h500, 32'hA5A5,   0, 32'h0,   32'h0,      1, 1,  32'hFFFFFFFF, 0,   0, 32'h500, 32'hA5A5,   1,  32'h0,        0);
        vecs[6] = mk("contested",          1, 32'h600, 32'h66,     1, 32'h700, 32'h77,     0, 1,  32'h11,       0,   0, 32'h600, 32'h66,     1,  32'h11,       0);
        vecs[7] = mk("addr_hold",          1, 32'h800, 32'h0,      0, 32'h0,   32'h0,      0, 3,  32'h88,       1,   0, 32'h800, 32'h0,      3,  32'h88,       0);
        vecs[8] = mk("dma_store_ok",       0, 32'h0,   32'h0,      1, 32'h900, 32'h1234,   1, 2,  32'h5555,     0,   1, 32'h900, 32'h1234,   2,  32'h0,        0);

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // Continuous contention: four CPU wins, then DMA is forced through.
        apply_reset();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hC00;
        dma_req = 1; dma_we = 0; dma_addr = 32'hD00;
        mem_ready = 0;
        ng = 0; both = 0; order_got = '0;
        order_exp = 10'b10_0001_0000;
        for (int c = 0; c < 200 && ng < 10; c++) begin
            @(negedge clk);
            if (cpu_gnt && dma_gnt) both = 1;
            if (cpu_gnt || dma_gnt) begin
                order_got[ng] = dma_gnt;
                ng++;
            end
            mem_ready = mem_req;
            mem_rdata = 32'(c);
        end
        check("starve_grants", 32'(ng), 32'd10);
        check("starve_order",  32'(order_got), 32'(order_exp));
        check("starve_double_gnt", 32'(both), 32'd0);
        cpu_req = 0; dma_req = 0; mem_ready = 0;
        apply_reset();

        // Reset asserted during the first BUSY cycle.
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hA00;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cpu_gnt) begin
                seen = 1;
                break;
            end
        end
        check("rstmid_gnt_seen", 32'(seen), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rstmid_mem_req",  32'(mem_req), 32'd0);
        check("rstmid_gnt",      32'(cpu_gnt), 32'd0);
        check("rstmid_mem_addr", mem_addr, 32'd0);
        cpu_req = 0;
        seen = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cpu_done || dma_done || mem_req) seen = 1;
        end
        check("rstmid_no_done", 32'(seen), 32'd0);
        run_txn(mk("post_reset", 1, 32'hB00, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h600DCAFE, 0,
                   0, 32'hB00, 32'h0, 1, 32'h600DCAFE, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
